// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall/flush sequencer for the 5-stage RV32I pipeline.
// Covers load-use stalls, taken-branch flushes, D-cache miss refill, E-stage forwarding and the stall counter.
module pipeline_hazard_ctrl #(
    parameter int REG_W = 5,
    parameter int BEATS = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rs1_e,
    input  logic [REG_W-1:0] rs2_e,
    input  logic [REG_W-1:0] rd_e,
    input  logic [REG_W-1:0] rd_m,
    input  logic [REG_W-1:0] rd_w,
    input  logic             load_e,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             pc_src_e,
    input  logic             cache_miss,
    input  logic             mem_ack,
    input  logic             mem_valid,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             stall_w,
    output logic             flush_d,
    output logic             flush_e,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             refill_req,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MISS_WAIT = 2'd1,
        REFILL    = 2'd2,
        RESUME    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             lu;

    function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs);
        if (reg_write_m && (rd_m != '0) && (rd_m == rs))
            return 2'b10;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            beat_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            RUN: begin
                if (cache_miss)
                    state_d = MISS_WAIT;
            end
            MISS_WAIT: begin
                // Beats arriving before the ack belong to nobody and are dropped.
                if (mem_ack) begin
                    state_d = REFILL;
                    beat_d  = '0;
                end
            end
            REFILL: begin
                if (mem_valid) begin
                    if (beat_q == BW'(BEATS - 1))
                        state_d = RESUME;
                    else
                        beat_d = beat_q + BW'(1);
                end
            end
            RESUME: begin
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    assign lu = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        stall_w    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        refill_req = 1'b0;
        busy       = 1'b0;
        fwd_a_e    = 2'b00;
        fwd_b_e    = 2'b00;
        if (rst) begin
            fwd_a_e = fwd_sel(rs1_e);
            fwd_b_e = fwd_sel(rs2_e);
            if (state_q == RUN) begin
                if (cache_miss) begin
                    {stall_f, stall_d, stall_e, stall_m, stall_w} = 5'b11111;
                end else if (pc_src_e) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (lu) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end else begin
                {stall_f, stall_d, stall_e, stall_m, stall_w} = 5'b11111;
                busy       = 1'b1;
                refill_req = (state_q == MISS_WAIT);
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (stall_f && (count_q != {CNT_W{1'b1}}))
            count_d = count_q + CNT_W'(1);
    end

    assign stall_count = count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with a 2-bit counter exercises saturation.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, reg_write_m, reg_write_w, pc_src_e, cache_miss, mem_ack, mem_valid;

    logic        stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, refill_req, busy;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic [15:0] stall_count;

    logic        s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_stall_w, s_flush_d, s_flush_e;
    logic        s_refill_req, s_busy;
    logic [1:0]  s_fwd_a_e, s_fwd_b_e;
    logic [1:0]  s_stall_count;

    logic [8:0]  ctl;
    assign ctl = {stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, refill_req, busy};

    localparam logic [8:0] C_IDLE   = 9'b000000000;
    localparam logic [8:0] C_LU     = 9'b110000100;
    localparam logic [8:0] C_BR     = 9'b000001100;
    localparam logic [8:0] C_MISS   = 9'b111110000;
    localparam logic [8:0] C_WAIT   = 9'b111110011;
    localparam logic [8:0] C_REFILL = 9'b111110001;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(5), .BEATS(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .load_e(load_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .pc_src_e(pc_src_e), .cache_miss(cache_miss), .mem_ack(mem_ack), .mem_valid(mem_valid),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
        .flush_d(flush_d), .flush_e(flush_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .refill_req(refill_req), .busy(busy), .stall_count(stall_count)
    );

    pipeline_hazard_ctrl #(.REG_W(5), .BEATS(4), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .load_e(load_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .pc_src_e(pc_src_e), .cache_miss(cache_miss), .mem_ack(mem_ack), .mem_valid(mem_valid),
        .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e), .stall_m(s_stall_m),
        .stall_w(s_stall_w), .flush_d(s_flush_d), .flush_e(s_flush_e),
        .fwd_a_e(s_fwd_a_e), .fwd_b_e(s_fwd_b_e),
        .refill_req(s_refill_req), .busy(s_busy), .stall_count(s_stall_count)
    );

    task automatic clear_inputs();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
        load_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
        pc_src_e = 1'b0; cache_miss = 1'b0; mem_ack = 1'b0; mem_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic set_load_use();
        load_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; rs2_d = 5'd1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        cache_miss = 1'b1;
        set_load_use();
        reg_write_m = 1'b1; rd_m = 5'd4; rs1_e = 5'd4; rs2_e = 5'd4;
        #3;
        total_cnt++;
        if (ctl !== C_IDLE) $display("FAIL reset_ctl: got %b expected %b", ctl, C_IDLE);
        else pass_cnt++;
        total_cnt++;
        if ({fwd_a_e, fwd_b_e} !== 4'b0000) $display("FAIL reset_fwd: got %b expected 0000", {fwd_a_e, fwd_b_e});
        else pass_cnt++;
        total_cnt++;
        if (stall_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", stall_count);
        else pass_cnt++;
        do_reset();
        #2;
        total_cnt++;
        if (ctl !== C_IDLE) $display("FAIL reset_release_ctl: got %b expected %b", ctl, C_IDLE);
        else pass_cnt++;
        $display("test_reset done");
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        set_load_use();
        #2;
        total_cnt++;
        if (ctl !== C_LU) $display("FAIL load_use_ctl: got %b expected %b", ctl, C_LU);
        else pass_cnt++;
        tick();
        clear_inputs();
        #2;
        total_cnt++;
        if (ctl !== C_IDLE) $display("FAIL load_use_after: got %b expected %b", ctl, C_IDLE);
        else pass_cnt++;
        total_cnt++;
        if (stall_count !== 16'd1) $display("FAIL load_use_count: got %0d expected 1", stall_count);
        else pass_cnt++;
        $display("test_load_use: ctl=%b count=%0d", ctl, stall_count);
        tick();
    endtask

    task automatic test_load_x0();
        do_reset();
        load_e = 1'b1; rd_e = 5'd0; rs1_d = 5'd0; rs2_d = 5'd0;
        #2;
        total_cnt++;
        if (ctl !== C_IDLE) $display("FAIL load_x0_ctl: got %b expected %b", ctl, C_IDLE);
        else pass_cnt++;
        $display("test_load_x0: ctl=%b", ctl);
        tick();
        clear_inputs();
    endtask

    task automatic test_branch_lu();
        do_reset();
        set_load_use();
        pc_src_e = 1'b1;
        #2;
        total_cnt++;
        if (ctl !== C_BR) $display("FAIL branch_lu_ctl: got %b expected %b", ctl, C_BR);
        else pass_cnt++;
        $display("test_branch_lu: ctl=%b", ctl);
        tick();
        clear_inputs();
    endtask

    // t=0 miss, ack at t=3, early beat at t=2 (ignored), beats at t=4,6,7,9, RESUME t=10, RUN t=11.
    task automatic test_miss();
        logic [8:0] exp_ctl;
        do_reset();
        cache_miss = 1'b1;
        #2;
        total_cnt++;
        if (ctl !== C_MISS) $display("FAIL miss_t0: got %b expected %b", ctl, C_MISS);
        else pass_cnt++;
        tick();
        for (int t = 1; t <= 11; t++) begin
            clear_inputs();
            mem_ack   = (t == 3);
            mem_valid = (t == 2) || (t == 4) || (t == 6) || (t == 7) || (t == 9);
            pc_src_e  = (t == 5);
            if (t == 8) set_load_use();
            if (t <= 3)       exp_ctl = C_WAIT;
            else if (t <= 10) exp_ctl = C_REFILL;
            else              exp_ctl = C_IDLE;
            #2;
            total_cnt++;
            if (ctl !== exp_ctl) $display("FAIL miss_t%0d: got %b expected %b", t, ctl, exp_ctl);
            else pass_cnt++;
            $display("test_miss t=%0d: ack=%b valid=%b ctl=%b", t, mem_ack, mem_valid, ctl);
            if (t == 11) begin
                total_cnt++;
                if (stall_count !== 16'd11) $display("FAIL miss_count: got %0d expected 11", stall_count);
                else pass_cnt++;
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_forwarding();
        logic [4:0] vec_rdm [4] = '{5'd7, 5'd7, 5'd0, 5'd3};
        logic [4:0] vec_rdw [4] = '{5'd7, 5'd7, 5'd0, 5'd9};
        logic       vec_rwm [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [4:0] vec_rs1 [4] = '{5'd7, 5'd7, 5'd0, 5'd9};
        logic [4:0] vec_rs2 [4] = '{5'd7, 5'd7, 5'd0, 5'd3};
        logic [3:0] vec_exp [4] = '{4'b1010, 4'b0101, 4'b0000, 4'b0110};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rd_m = vec_rdm[i]; rd_w = vec_rdw[i];
            reg_write_m = vec_rwm[i]; reg_write_w = 1'b1;
            rs1_e = vec_rs1[i]; rs2_e = vec_rs2[i];
            #2;
            total_cnt++;
            if ({fwd_a_e, fwd_b_e} !== vec_exp[i])
                $display("FAIL fwd_%0d: got a=%b b=%b expected %b", i, fwd_a_e, fwd_b_e, vec_exp[i]);
            else pass_cnt++;
            $display("test_forwarding %0d: a=%b b=%b", i, fwd_a_e, fwd_b_e);
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_refill();
        do_reset();
        cache_miss = 1'b1;
        tick();
        clear_inputs(); mem_ack = 1'b1;
        tick();
        clear_inputs(); mem_valid = 1'b1;
        tick();
        tick();
        clear_inputs();
        reg_write_m = 1'b1; rd_m = 5'd6; rs1_e = 5'd6;
        #1;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (ctl !== C_IDLE) $display("FAIL midrst_ctl: got %b expected %b", ctl, C_IDLE);
        else pass_cnt++;
        total_cnt++;
        if ({fwd_a_e, stall_count} !== 18'd0) $display("FAIL midrst_fwd_count: got fwd=%b count=%0d expected 0", fwd_a_e, stall_count);
        else pass_cnt++;
        tick();
        rst = 1'b1;
        clear_inputs();
        tick();
        cache_miss = 1'b1;
        tick();
        clear_inputs(); mem_ack = 1'b1;
        tick();
        for (int b = 1; b <= 5; b++) begin
            clear_inputs();
            mem_valid = (b <= 4);
            #2;
            total_cnt++;
            if (ctl !== C_REFILL) $display("FAIL midrst_beat%0d: got %b expected %b", b, ctl, C_REFILL);
            else pass_cnt++;
            tick();
        end
        clear_inputs();
        #2;
        total_cnt++;
        if (ctl !== C_IDLE) $display("FAIL midrst_run: got %b expected %b", ctl, C_IDLE);
        else pass_cnt++;
        $display("test_reset_mid_refill: ctl=%b count=%0d", ctl, stall_count);
        tick();
    endtask

    task automatic test_saturation();
        int exp_sat;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            set_load_use();
            tick();
            clear_inputs();
            #1;
            exp_sat = (k > 3) ? 3 : k;
            total_cnt++;
            if (s_stall_count !== 2'(exp_sat) || stall_count !== 16'(k))
                $display("FAIL sat_%0d: got sat=%0d main=%0d expected sat=%0d main=%0d",
                         k, s_stall_count, stall_count, exp_sat, k);
            else pass_cnt++;
            $display("test_saturation %0d: sat=%0d main=%0d", k, s_stall_count, stall_count);
        end
        tick();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_load_use();
        test_load_x0();
        test_branch_lu();
        test_miss();
        test_forwarding();
        test_reset_mid_refill();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
